// File: rtl/product_accumulator.sv
// Accumulate half of a multiply-accumulate path: buffers signed products in a
// 2-entry FIFO and sums N_TERMS of them into a saturating signed total.
module product_accumulator #(
  parameter int PROD_W  = 8,
  parameter int ACC_W   = 10,
  parameter int N_TERMS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              sat_flag,
  output logic [3:0]        term_count
);

  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  localparam logic [ACC_W:0] MAX_V = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W:0] MIN_V = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic [3:0]     TERMS = 4'(N_TERMS);

  logic [0:0]        state;
  logic [PROD_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;
  logic [PROD_W-1:0] head;
  logic [ACC_W:0]    sum;
  logic              sat_hi;
  logic              sat_lo;
  logic [ACC_W-1:0]  clamped;
  logic [3:0]        term_next;

  // Ready looks only at registered occupancy, so a full FIFO never admits a
  // push even when it is being popped in the same cycle.
  assign prod_ready = (count != 2'd2);
  assign push       = prod_valid && prod_ready && !clear;
  assign pop        = (state == ST_ACC) && (count != 2'd0) && !clear;
  assign head       = mem[rd_ptr];
  assign acc_valid  = (state == ST_OUT);

  // One extra bit of headroom makes any overflow visible before clamping.
  assign sum     = {acc_out[ACC_W-1], acc_out}
                 + {{(ACC_W+1-PROD_W){head[PROD_W-1]}}, head};
  assign sat_hi  = $signed(sum) > $signed(MAX_V);
  assign sat_lo  = $signed(sum) < $signed(MIN_V);
  assign clamped = sat_hi ? MAX_V[ACC_W-1:0] :
                   sat_lo ? MIN_V[ACC_W-1:0] : sum[ACC_W-1:0];
  assign term_next = term_count + 4'd1;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= prod_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_ACC;
      acc_out    <= '0;
      sat_flag   <= 1'b0;
      term_count <= 4'd0;
    end else if (clear) begin
      state      <= ST_ACC;
      acc_out    <= '0;
      sat_flag   <= 1'b0;
      term_count <= 4'd0;
    end else if (state == ST_ACC) begin
      if (pop) begin
        acc_out    <= clamped;
        term_count <= term_next;
        if (sat_hi || sat_lo) sat_flag <= 1'b1;
        if (term_next == TERMS) state <= ST_OUT;
      end
    end else if (acc_ready) begin
      state      <= ST_ACC;
      acc_out    <= '0;
      sat_flag   <= 1'b0;
      term_count <= 4'd0;
    end
  end

endmodule
